jpeg_mcu_seq: RTL and testbench

Downstream of the SOF header parser. Consumes the frame geometry and quant-table selections it publishes (co_en, co_411, co_mcu_w/h, sof_*_qt) and sequences entropy-decoded 8x8 blocks through the frame. Per accepted block it advances block-in-MCU, MCU column and MCU row, and drives component and quant-table selects for dequant/IDCT. It also handles DRI restart-interval handshakes and flags end of frame.

---
 rtl/jpeg_mcu_seq_pkg.sv | 34 +++
 rtl/jpeg_mcu_pos.sv | 78 +++++++
 rtl/jpeg_mcu_seq.sv | 197 +++++++++++++++++++
 tb/tb_jpeg_mcu_seq.sv | 333 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/jpeg_mcu_seq_pkg.sv
// Shared definitions for the MCU sequencer: top-decoder state codes, component
// codes, blocks-per-MCU for each sampling mode and the sequencer FSM encoding.
package jpeg_mcu_seq_pkg;

    // Top decoder state codes; STATE_RST forces every downstream stage to clear.
    localparam logic [3:0] STATE_IDLE = 4'd0;
    localparam logic [3:0] STATE_RST  = 4'd1;
    localparam logic [3:0] STATE_SOF  = 4'd2;
    localparam logic [3:0] STATE_SCAN = 4'd3;

    localparam logic [1:0] COMP_Y  = 2'd0;
    localparam logic [1:0] COMP_CB = 2'd1;
    localparam logic [1:0] COMP_CR = 2'd2;

    localparam int unsigned BLK_PER_MCU_411 = 6;
    localparam int unsigned BLK_PER_MCU_444 = 3;

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StRstWait,
        StDone
    } seq_state_e;

    // Component of a block index: 411 has four luma blocks before Cb/Cr.
    function automatic logic [1:0] blk_comp(input logic [2:0] blk, input logic is_411);
        logic [2:0] last_y;
        last_y = is_411 ? 3'd3 : 3'd0;
        if (blk <= last_y)              return COMP_Y;
        else if (blk == last_y + 3'd1)  return COMP_CB;
        else                            return COMP_CR;
    endfunction

endpackage

// File: rtl/jpeg_mcu_pos.sv
// Block / MCU-column / MCU-row position counter.
// Ports:
//   clk, rst        clock, async active-low reset
//   clr             synchronous clear to (blk,x,y) = 0
//   adv             advance by one block on the next edge
//   is_411          1: 6 blocks per MCU, 0: 3 blocks per MCU
//   w, h            frame size in MCUs (non-zero while advancing)
//   blk, x, y       current position
//   mcu_last_blk    current block is the last of its MCU
//   frame_last_mcu  current MCU is the last of the frame
module jpeg_mcu_pos import jpeg_mcu_seq_pkg::*; #(
    parameter int unsigned MCU_BITS = 13
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                clr,
    input  logic                adv,
    input  logic                is_411,
    input  logic [MCU_BITS-1:0] w,
    input  logic [MCU_BITS-1:0] h,
    output logic [2:0]          blk,
    output logic [MCU_BITS-1:0] x,
    output logic [MCU_BITS-1:0] y,
    output logic                mcu_last_blk,
    output logic                frame_last_mcu
);

    logic [2:0]          blk_q, blk_d;
    logic [MCU_BITS-1:0] x_q, x_d, y_q, y_d;
    logic                x_last, y_last;

    assign mcu_last_blk   = is_411 ? (blk_q == 3'(BLK_PER_MCU_411 - 1))
                                   : (blk_q == 3'(BLK_PER_MCU_444 - 1));
    assign x_last         = (x_q == w - MCU_BITS'(1));
    assign y_last         = (y_q == h - MCU_BITS'(1));
    assign frame_last_mcu = x_last & y_last;

    // Every increment is guarded by a compare against its bound, so nothing wraps.
    always_comb begin
        blk_d = blk_q;
        x_d   = x_q;
        y_d   = y_q;
        if (clr) begin
            blk_d = '0;
            x_d   = '0;
            y_d   = '0;
        end else if (adv) begin
            if (!mcu_last_blk) begin
                blk_d = blk_q + 3'd1;
            end else begin
                blk_d = '0;
                if (!x_last) begin
                    x_d = x_q + MCU_BITS'(1);
                end else if (!y_last) begin
                    x_d = '0;
                    y_d = y_q + MCU_BITS'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            blk_q <= '0;
            x_q   <= '0;
            y_q   <= '0;
        end else begin
            blk_q <= blk_d;
            x_q   <= x_d;
            y_q   <= y_d;
        end
    end

    assign blk = blk_q;
    assign x   = x_q;
    assign y   = y_q;

endmodule

// File: rtl/jpeg_mcu_seq.sv
// MCU sequencer: walks entropy-decoded 8x8 blocks through the frame geometry
// published by the SOF parser, drives component / quant-table selects, handles
// DRI restart handshakes and flags end of frame.
// Ports:
//   clk, rst                 clock, async active-low reset
//   state                    top decoder state (STATE_RST clears synchronously)
//   co_en, co_411            geometry valid, 411 sampling select
//   co_mcu_w, co_mcu_h       frame size in MCUs
//   sof_*_qt                 quant table ids per component
//   dri_interval             MCUs per restart interval (0 = none)
//   blk_done / blk_ready     block handshake
//   cur_comp/cur_qt/cur_blk  current block selects
//   mcu_x, mcu_y             current MCU position
//   mcu_done, dc_clr, frame_done  one-cycle registered pulses
//   rst_req / rst_ack        restart marker handshake
module jpeg_mcu_seq import jpeg_mcu_seq_pkg::*; #(
    parameter int unsigned MCU_BITS = 13,
    parameter int unsigned DRI_BITS = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [3:0]          state,
    input  logic                co_en,
    input  logic                co_411,
    input  logic [MCU_BITS-1:0] co_mcu_w,
    input  logic [MCU_BITS-1:0] co_mcu_h,
    input  logic [1:0]          sof_y_qt,
    input  logic [1:0]          sof_cb_qt,
    input  logic [1:0]          sof_cr_qt,
    input  logic [DRI_BITS-1:0] dri_interval,
    input  logic                blk_done,
    output logic                blk_ready,
    output logic [1:0]          cur_comp,
    output logic [1:0]          cur_qt,
    output logic [2:0]          cur_blk,
    output logic [MCU_BITS-1:0] mcu_x,
    output logic [MCU_BITS-1:0] mcu_y,
    output logic                mcu_done,
    output logic                rst_req,
    input  logic                rst_ack,
    output logic                dc_clr,
    output logic                frame_done
);

    seq_state_e          fsm_q, fsm_d;
    logic [MCU_BITS-1:0] w_q, w_d, h_q, h_d;
    logic                is411_q, is411_d;
    logic [DRI_BITS-1:0] dri_q, dri_d, rcnt_q, rcnt_d;
    logic [1:0]          yqt_q, yqt_d, cbqt_q, cbqt_d, crqt_q, crqt_d;
    logic                mcu_done_q, mcu_done_d, dc_clr_q, dc_clr_d;
    logic                frame_done_q, frame_done_d;

    logic sync_clr, accept, mcu_last_blk, frame_last_mcu, pos_adv;

    assign sync_clr  = (state == STATE_RST);
    assign blk_ready = (fsm_q == StRun);
    assign rst_req   = (fsm_q == StRstWait);
    assign accept    = blk_ready & blk_done;
    // The final block of the frame leaves the position parked on the last MCU.
    assign pos_adv   = accept & ~(mcu_last_blk & frame_last_mcu);

    jpeg_mcu_pos #(
        .MCU_BITS (MCU_BITS)
    ) u_pos (
        .clk            (clk),
        .rst            (rst),
        .clr            (sync_clr),
        .adv            (pos_adv),
        .is_411         (is411_q),
        .w              (w_q),
        .h              (h_q),
        .blk            (cur_blk),
        .x              (mcu_x),
        .y              (mcu_y),
        .mcu_last_blk   (mcu_last_blk),
        .frame_last_mcu (frame_last_mcu)
    );

    always_comb begin
        fsm_d        = fsm_q;
        w_d          = w_q;
        h_d          = h_q;
        is411_d      = is411_q;
        dri_d        = dri_q;
        rcnt_d       = rcnt_q;
        yqt_d        = yqt_q;
        cbqt_d       = cbqt_q;
        crqt_d       = crqt_q;
        mcu_done_d   = 1'b0;
        dc_clr_d     = 1'b0;
        frame_done_d = 1'b0;

        unique case (fsm_q)
            StIdle: begin
                if (co_en) begin
                    if (co_mcu_w == '0 || co_mcu_h == '0) begin
                        frame_done_d = 1'b1;
                        fsm_d        = StDone;
                    end else begin
                        w_d      = co_mcu_w;
                        h_d      = co_mcu_h;
                        is411_d  = co_411;
                        dri_d    = dri_interval;
                        yqt_d    = sof_y_qt;
                        cbqt_d   = sof_cb_qt;
                        crqt_d   = sof_cr_qt;
                        dc_clr_d = 1'b1;
                        fsm_d    = StRun;
                    end
                end
            end
            StRun: begin
                if (accept && mcu_last_blk) begin
                    mcu_done_d = 1'b1;
                    if (frame_last_mcu) begin
                        frame_done_d = 1'b1;
                        fsm_d        = StDone;
                    end else if (dri_q != '0 && rcnt_q == dri_q - DRI_BITS'(1)) begin
                        rcnt_d = '0;
                        fsm_d  = StRstWait;
                    end else begin
                        rcnt_d = rcnt_q + DRI_BITS'(1);
                    end
                end
            end
            StRstWait: begin
                if (rst_ack) begin
                    dc_clr_d = 1'b1;
                    fsm_d    = StRun;
                end
            end
            StDone: ;
            default: fsm_d = StIdle;
        endcase

        if (sync_clr) begin
            fsm_d        = StIdle;
            w_d          = '0;
            h_d          = '0;
            is411_d      = 1'b0;
            dri_d        = '0;
            rcnt_d       = '0;
            yqt_d        = '0;
            cbqt_d       = '0;
            crqt_d       = '0;
            mcu_done_d   = 1'b0;
            dc_clr_d     = 1'b0;
            frame_done_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fsm_q        <= StIdle;
            w_q          <= '0;
            h_q          <= '0;
            is411_q      <= 1'b0;
            dri_q        <= '0;
            rcnt_q       <= '0;
            yqt_q        <= '0;
            cbqt_q       <= '0;
            crqt_q       <= '0;
            mcu_done_q   <= 1'b0;
            dc_clr_q     <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            fsm_q        <= fsm_d;
            w_q          <= w_d;
            h_q          <= h_d;
            is411_q      <= is411_d;
            dri_q        <= dri_d;
            rcnt_q       <= rcnt_d;
            yqt_q        <= yqt_d;
            cbqt_q       <= cbqt_d;
            crqt_q       <= crqt_d;
            mcu_done_q   <= mcu_done_d;
            dc_clr_q     <= dc_clr_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign cur_comp = blk_comp(cur_blk, is411_q);

    always_comb begin
        cur_qt = crqt_q;
        case (cur_comp)
            COMP_Y:  cur_qt = yqt_q;
            COMP_CB: cur_qt = cbqt_q;
            default: cur_qt = crqt_q;
        endcase
    end

    assign mcu_done   = mcu_done_q;
    assign dc_clr     = dc_clr_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_jpeg_mcu_seq.sv
module tb_jpeg_mcu_seq;
    import jpeg_mcu_seq_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  state;
    logic        co_en, co_411;
    logic [12:0] co_mcu_w, co_mcu_h;
    logic [1:0]  sof_y_qt, sof_cb_qt, sof_cr_qt;
    logic [15:0] dri_interval;
    logic        blk_done, blk_ready;
    logic [1:0]  cur_comp, cur_qt;
    logic [2:0]  cur_blk;
    logic [12:0] mcu_x, mcu_y;
    logic        mcu_done, rst_req, rst_ack, dc_clr, frame_done;

    int n_cmp = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    jpeg_mcu_seq dut (
        .clk          (clk),
        .rst          (rst),
        .state        (state),
        .co_en        (co_en),
        .co_411       (co_411),
        .co_mcu_w     (co_mcu_w),
        .co_mcu_h     (co_mcu_h),
        .sof_y_qt     (sof_y_qt),
        .sof_cb_qt    (sof_cb_qt),
        .sof_cr_qt    (sof_cr_qt),
        .dri_interval (dri_interval),
        .blk_done     (blk_done),
        .blk_ready    (blk_ready),
        .cur_comp     (cur_comp),
        .cur_qt       (cur_qt),
        .cur_blk      (cur_blk),
        .mcu_x        (mcu_x),
        .mcu_y        (mcu_y),
        .mcu_done     (mcu_done),
        .rst_req      (rst_req),
        .rst_ack      (rst_ack),
        .dc_clr       (dc_clr),
        .frame_done   (frame_done)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_blk();
        blk_done = 1'b1;
        tick();
        blk_done = 1'b0;
    endtask

    task automatic pulse_ack();
        rst_ack = 1'b1;
        tick();
        rst_ack = 1'b0;
    endtask

    task automatic sync_clear();
        co_en = 1'b0;
        state = STATE_RST;
        tick();
        state = STATE_SCAN;
    endtask

    task automatic start_frame(input logic f411, input int w, input int h, input int dri);
        sync_clear();
        co_411 = f411;
        co_mcu_w = 13'(w);
        co_mcu_h = 13'(h);
        dri_interval = 16'(dri);
        co_en = 1'b1;
        tick();
        n_cmp++;
        if (dc_clr !== 1'b1) begin
            n_fail++; $display("FAIL start_dc_clr: got %b want 1", dc_clr);
        end
        n_cmp++;
        if (blk_ready !== 1'b1) begin
            n_fail++; $display("FAIL start_blk_ready: got %b want 1", blk_ready);
        end
    endtask

    task automatic test_reset();
        rst = 1'b0; state = STATE_SCAN; co_en = 0; co_411 = 0; co_mcu_w = 0; co_mcu_h = 0;
        sof_y_qt = 2'd1; sof_cb_qt = 2'd2; sof_cr_qt = 2'd3; dri_interval = 0;
        blk_done = 0; rst_ack = 0;
        #3;
        n_cmp++;
        if ({blk_ready, mcu_done, rst_req, dc_clr, frame_done} !== 5'b0) begin
            n_fail++;
            $display("FAIL reset_flags: got %b want 00000",
                     {blk_ready, mcu_done, rst_req, dc_clr, frame_done});
        end
        n_cmp++;
        if ({cur_comp, cur_qt, cur_blk, mcu_x, mcu_y} !== 33'b0) begin
            n_fail++;
            $display("FAIL reset_pos: comp %0d qt %0d blk %0d x %0d y %0d want all 0",
                     cur_comp, cur_qt, cur_blk, mcu_x, mcu_y);
        end
        tick();
        rst = 1'b1;
        tick();
        n_cmp++;
        if (blk_ready !== 1'b0) begin
            n_fail++; $display("FAIL reset_idle: blk_ready got %b want 0", blk_ready);
        end
    endtask

    task automatic test_411_frame();
        int mcus = 0;
        sof_y_qt = 2'd1; sof_cb_qt = 2'd2; sof_cr_qt = 2'd3;
        start_frame(1'b1, 2, 2, 0);
        sof_y_qt = 2'd0;  // must be ignored: selects were captured at frame start
        for (int i = 0; i < 24; i++) begin
            int b = i % 6;
            int m = i / 6;
            logic [1:0] ec = (b < 4) ? 2'd0 : ((b == 4) ? 2'd1 : 2'd2);
            n_cmp++;
            if (cur_comp !== ec || cur_qt !== ec + 2'd1 || cur_blk !== 3'(b)) begin
                n_fail++;
                $display("FAIL f411_sel[%0d]: comp %0d qt %0d blk %0d want %0d %0d %0d",
                         i, cur_comp, cur_qt, cur_blk, ec, ec + 2'd1, b);
            end
            n_cmp++;
            if (mcu_x !== 13'(m % 2) || mcu_y !== 13'(m / 2)) begin
                n_fail++;
                $display("FAIL f411_xy[%0d]: got (%0d,%0d) want (%0d,%0d)",
                         i, mcu_x, mcu_y, m % 2, m / 2);
            end
            pulse_blk();
            if (mcu_done === 1'b1) mcus++;
            n_cmp++;
            if (mcu_done !== (b == 5) || frame_done !== (i == 23)) begin
                n_fail++;
                $display("FAIL f411_pulse[%0d]: mcu_done %b frame_done %b want %b %b",
                         i, mcu_done, frame_done, b == 5, i == 23);
            end
        end
        n_cmp++;
        if (mcus != 4 || blk_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL f411_end: mcus %0d blk_ready %b want 4 0", mcus, blk_ready);
        end
        tick();
        n_cmp++;
        if (frame_done !== 1'b0 || blk_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL f411_done_hold: frame_done %b blk_ready %b want 0 0",
                     frame_done, blk_ready);
        end
    endtask

    task automatic test_restart();
        start_frame(1'b0, 3, 1, 2);
        pulse_ack();
        n_cmp++;
        if (dc_clr !== 1'b0) begin
            n_fail++; $display("FAIL rst_stray_ack: dc_clr got %b want 0", dc_clr);
        end
        for (int i = 0; i < 6; i++) begin
            pulse_blk();
            n_cmp++;
            if (rst_req !== (i == 5)) begin
                n_fail++; $display("FAIL rst_req_blk[%0d]: got %b want %b", i, rst_req, i == 5);
            end
        end
        n_cmp++;
        if (blk_ready !== 1'b0 || mcu_x !== 13'd2 || mcu_done !== 1'b1) begin
            n_fail++;
            $display("FAIL rst_wait_entry: ready %b x %0d mcu_done %b want 0 2 1",
                     blk_ready, mcu_x, mcu_done);
        end
        pulse_blk();
        tick();
        n_cmp++;
        if (cur_blk !== 3'd0 || mcu_x !== 13'd2 || rst_req !== 1'b1) begin
            n_fail++;
            $display("FAIL rst_wait_ignore: blk %0d x %0d rst_req %b want 0 2 1",
                     cur_blk, mcu_x, rst_req);
        end
        pulse_ack();
        n_cmp++;
        if (rst_req !== 1'b0 || dc_clr !== 1'b1 || blk_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL rst_ack: rst_req %b dc_clr %b ready %b want 0 1 1",
                     rst_req, dc_clr, blk_ready);
        end
        for (int i = 0; i < 3; i++) begin
            pulse_blk();
            n_cmp++;
            if (frame_done !== (i == 2) || rst_req !== 1'b0) begin
                n_fail++;
                $display("FAIL rst_tail[%0d]: frame_done %b rst_req %b want %b 0",
                         i, frame_done, rst_req, i == 2);
            end
        end
    endtask

    task automatic test_dri_coincide();
        int rq = 0;
        int mcus = 0;
        start_frame(1'b1, 2, 2, 4);
        for (int i = 0; i < 24; i++) begin
            pulse_blk();
            if (rst_req === 1'b1) rq++;
            if (mcu_done === 1'b1) mcus++;
        end
        n_cmp++;
        if (rq != 0 || mcus != 4 || frame_done !== 1'b1) begin
            n_fail++;
            $display("FAIL dri_coincide: rst_req cycles %0d mcus %0d frame_done %b want 0 4 1",
                     rq, mcus, frame_done);
        end
    endtask

    task automatic test_zero_width();
        sync_clear();
        co_411 = 1'b0; co_mcu_w = 13'd0; co_mcu_h = 13'd5; dri_interval = 16'd0;
        co_en = 1'b1;
        tick();
        n_cmp++;
        if (frame_done !== 1'b1 || dc_clr !== 1'b0 || blk_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL zero_w: frame_done %b dc_clr %b ready %b want 1 0 0",
                     frame_done, dc_clr, blk_ready);
        end
        for (int i = 0; i < 3; i++) begin
            pulse_blk();
            n_cmp++;
            if (blk_ready !== 1'b0 || frame_done !== 1'b0 || cur_blk !== 3'd0) begin
                n_fail++;
                $display("FAIL zero_w_hold[%0d]: ready %b frame_done %b blk %0d want 0 0 0",
                         i, blk_ready, frame_done, cur_blk);
            end
        end
    endtask

    task automatic test_state_rst();
        start_frame(1'b1, 2, 2, 0);
        for (int i = 0; i < 9; i++) pulse_blk();
        n_cmp++;
        if (mcu_x !== 13'd1 || cur_blk !== 3'd3) begin
            n_fail++; $display("FAIL srst_pre: x %0d blk %0d want 1 3", mcu_x, cur_blk);
        end
        state = STATE_RST;  // co_en still high: clear must win
        blk_done = 1'b1;
        tick();
        blk_done = 1'b0;
        n_cmp++;
        if ({mcu_x, mcu_y, cur_blk, blk_ready, rst_req, dc_clr} !== 32'b0) begin
            n_fail++;
            $display("FAIL srst_run: x %0d y %0d blk %0d ready %b rst_req %b dc_clr %b want 0",
                     mcu_x, mcu_y, cur_blk, blk_ready, rst_req, dc_clr);
        end
        state = STATE_SCAN;
        tick();
        n_cmp++;
        if (dc_clr !== 1'b1 || blk_ready !== 1'b1 || cur_blk !== 3'd0) begin
            n_fail++;
            $display("FAIL srst_restart: dc_clr %b ready %b blk %0d want 1 1 0",
                     dc_clr, blk_ready, cur_blk);
        end
        start_frame(1'b0, 3, 1, 1);
        for (int i = 0; i < 3; i++) pulse_blk();
        n_cmp++;
        if (rst_req !== 1'b1) begin
            n_fail++; $display("FAIL srst_wait_pre: rst_req got %b want 1", rst_req);
        end
        state = STATE_RST;
        tick();
        state = STATE_SCAN;
        n_cmp++;
        if (rst_req !== 1'b0 || mcu_x !== 13'd0 || blk_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL srst_wait: rst_req %b x %0d ready %b want 0 0 0",
                     rst_req, mcu_x, blk_ready);
        end
    endtask

    task automatic test_async_reset();
        start_frame(1'b0, 3, 2, 0);
        for (int i = 0; i < 4; i++) pulse_blk();
        n_cmp++;
        if (mcu_x !== 13'd1 || cur_blk !== 3'd1) begin
            n_fail++; $display("FAIL areset_pre: x %0d blk %0d want 1 1", mcu_x, cur_blk);
        end
        #2;
        rst = 1'b0;
        #1;  // still before the next rising edge
        n_cmp++;
        if (blk_ready !== 1'b0 || mcu_x !== 13'd0 || cur_blk !== 3'd0) begin
            n_fail++;
            $display("FAIL areset_async: ready %b x %0d blk %0d want 0 0 0",
                     blk_ready, mcu_x, cur_blk);
        end
        co_en = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        n_cmp++;
        if (blk_ready !== 1'b0 || dc_clr !== 1'b0) begin
            n_fail++;
            $display("FAIL areset_idle: ready %b dc_clr %b want 0 0", blk_ready, dc_clr);
        end
        co_en = 1'b1;
        tick();
        n_cmp++;
        if (dc_clr !== 1'b1 || blk_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL areset_restart: dc_clr %b ready %b want 1 1", dc_clr, blk_ready);
        end
    endtask

    initial begin
        test_reset();
        test_411_frame();
        test_restart();
        test_dri_coincide();
        test_zero_width();
        test_state_rst();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
